// File: rtl/rf_pulse_modulator_if.sv
// Bundle of the rf gate input, carrier controls and modulator outputs.
// master = the pulse sequencer side; slave = the modulator.
interface rf_pulse_modulator_if #(
  parameter int PHASE_W = 16,
  parameter int IDX_W   = 8
);
  // Level signals sampled every rising clk edge; there is no valid/ready
  // pair: rf_in/clr/ftw/phase_odd must be stable at each edge, outputs are
  // registered and change only on edges.
  logic               rf_in;
  logic               clr;
  logic [PHASE_W-1:0] ftw;
  logic [PHASE_W-1:0] phase_odd;
  logic               tx_en;
  logic               carrier;
  logic               rx_blank;
  logic [IDX_W-1:0]   pulse_idx;
  logic               err;
  logic [1:0]         fsm_state;

  modport master (
    output rf_in, clr, ftw, phase_odd,
    input  tx_en, carrier, rx_blank, pulse_idx, err, fsm_state
  );

  modport slave (
    input  rf_in, clr, ftw, phase_odd,
    output tx_en, carrier, rx_blank, pulse_idx, err, fsm_state
  );
endinterface

// File: rtl/rf_pulse_modulator.sv
// Delays the sequencer rf gate into tx_en, gates a phase-coherent carrier,
// and wraps each transmit pulse in a receiver blanking window.
module rf_pulse_modulator #(
  parameter int PHASE_W = 16,
  parameter int LEAD    = 4,
  parameter int POST    = 6,
  parameter int MIN_W   = 2,
  parameter int IDX_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_pulse_modulator_if.slave  bus
);

  localparam int CNT_W = (POST > 1) ? $clog2(POST) : 1;
  localparam int RUN_W = $clog2(MIN_W + 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = (POST > 0) ? CNT_W'(POST - 1) : '0;
  localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(MIN_W);
  localparam logic [PHASE_W-1:0] HALF_TURN = {1'b1, {(PHASE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [LEAD-1:0]    r_dly;
  logic [LEAD:0]      w_shift;
  logic [CNT_W-1:0]   r_hold;
  logic [RUN_W-1:0]   r_run;
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] w_offset;
  logic [PHASE_W-1:0] w_phase;
  logic [IDX_W-1:0]   r_idx;
  logic               r_tx_en;
  logic               r_carrier;
  logic               r_rx_blank;
  logic               r_err;
  logic               w_tx_nxt;
  logic               w_tx_fall;
  logic               w_dly_empty;
  logic               w_runt;

  // r_dly[k] holds the rf_in sample from k+1 edges ago; tx_en takes the
  // oldest one, giving exactly LEAD edges from sample to tx_en.
  assign w_shift     = {r_dly, bus.rf_in};
  assign w_tx_nxt    = r_dly[LEAD-1];
  assign w_tx_fall   = r_tx_en & ~w_tx_nxt;
  assign w_dly_empty = (r_dly == '0);
  assign w_runt      = ~bus.rf_in && (r_run != '0) && (r_run < RUN_MAX);
  assign w_offset    = r_idx[0] ? bus.phase_odd : '0;
  assign w_phase     = r_acc + w_offset;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.rf_in) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!bus.rf_in && w_dly_empty) w_state_nxt = (POST == 0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.rf_in)                w_state_nxt = ST_ACTIVE;
        else if (r_hold == HOLD_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_dly      <= '0;
      r_hold     <= '0;
      r_run      <= '0;
      r_tx_en    <= 1'b0;
      r_carrier  <= 1'b0;
      r_rx_blank <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dly      <= w_shift[LEAD-1:0];
      r_hold     <= (r_state == ST_HOLD && w_state_nxt == ST_HOLD) ? r_hold + CNT_W'(1) : '0;
      r_run      <= !bus.rf_in ? '0 : ((r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1));
      r_tx_en    <= w_tx_nxt;
      r_carrier  <= w_tx_nxt & (w_phase >= HALF_TURN);
      r_rx_blank <= (w_state_nxt != ST_IDLE);
    end
  end

  // clr has priority over the pulse count increment and runt detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else if (bus.clr) begin
      r_acc <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      r_acc <= r_acc + bus.ftw;
      if (w_tx_fall) r_idx <= r_idx + IDX_W'(1);
      if (w_runt)    r_err <= 1'b1;
    end
  end

  assign bus.tx_en     = r_tx_en;
  assign bus.carrier   = r_carrier;
  assign bus.rx_blank  = r_rx_blank;
  assign bus.pulse_idx = r_idx;
  assign bus.err       = r_err;
  assign bus.fsm_state = r_state;

endmodule

// File: tb/tb_rf_pulse_modulator.sv
// Bench for rf_pulse_modulator: a history-window reference model predicts every
// cycle's outputs; a second instance built with POST=0 shares the stimulus.
module tb_rf_pulse_modulator;
  localparam int PHASE_W = 16;
  localparam int LEAD    = 4;
  localparam int POST    = 6;
  localparam int MIN_W   = 2;
  localparam int IDX_W   = 8;
  localparam int EXP_W   = 3 + IDX_W + 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [EXP_W-1:0] exp_q[$];

  // reference model state: m_hist[k] = rf_in sampled k edges ago
  logic [63:0]        m_hist;
  int                 m_run;
  logic [PHASE_W-1:0] m_acc;
  logic [IDX_W-1:0]   m_idx;
  logic               m_err;

  rf_pulse_modulator_if #(.PHASE_W(PHASE_W), .IDX_W(IDX_W)) if_a ();
  rf_pulse_modulator_if #(.PHASE_W(PHASE_W), .IDX_W(IDX_W)) if_b ();

  assign if_b.rf_in     = if_a.rf_in;
  assign if_b.clr       = if_a.clr;
  assign if_b.ftw       = if_a.ftw;
  assign if_b.phase_odd = if_a.phase_odd;

  rf_pulse_modulator #(.PHASE_W(PHASE_W), .LEAD(LEAD), .POST(POST), .MIN_W(MIN_W), .IDX_W(IDX_W))
    dut (.clk(clk), .rst_n(rst_n), .bus(if_a));

  rf_pulse_modulator #(.PHASE_W(PHASE_W), .LEAD(LEAD), .POST(0), .MIN_W(MIN_W), .IDX_W(IDX_W))
    dut_p0 (.clk(clk), .rst_n(rst_n), .bus(if_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = '0;
    m_run  = 0;
    m_acc  = '0;
    m_idx  = '0;
    m_err  = 1'b0;
  endtask

  // Predicts outputs after the coming edge from the rf_in history window.
  task automatic model_edge(input logic rf, input logic c, output logic [EXP_W-1:0] e);
    logic tx, tx_prev, blk, blk0, car, fall, runt;
    logic [PHASE_W-1:0] sum;
    m_hist  = {m_hist[62:0], rf};
    tx      = m_hist[LEAD];
    tx_prev = m_hist[LEAD+1];
    fall    = tx_prev & ~tx;
    blk     = 1'b0;
    blk0    = 1'b0;
    for (int k = 0; k <= LEAD + POST; k++) blk  |= m_hist[k];
    for (int k = 0; k <= LEAD; k++)        blk0 |= m_hist[k];
    runt  = !rf && (m_run > 0) && (m_run < MIN_W);
    m_run = rf ? m_run + 1 : 0;
    sum   = m_acc + (m_idx[0] ? if_a.phase_odd : '0);
    car   = sum[PHASE_W-1] & tx;
    if (c) begin
      m_acc = '0;
      m_idx = '0;
      m_err = 1'b0;
    end else begin
      m_acc = m_acc + if_a.ftw;
      if (fall) m_idx = m_idx + 1'b1;
      if (runt) m_err = 1'b1;
    end
    e = {tx, car, blk, m_idx, m_err, blk0};
  endtask

  // driver: one clock of stimulus, scoreboard push before the edge, pop after it
  task automatic step(input logic rf, input logic c);
    logic [EXP_W-1:0] e;
    if_a.rf_in = rf;
    if_a.clr   = c;
    model_edge(rf, c, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("tx_en",     if_a.tx_en,     e[EXP_W-1]);
    check_eq("carrier",   if_a.carrier,   e[EXP_W-2]);
    check_eq("rx_blank",  if_a.rx_blank,  e[EXP_W-3]);
    check_eq("pulse_idx", if_a.pulse_idx, e[IDX_W+1:2]);
    check_eq("err",       if_a.err,       e[1]);
    check_eq("p0_tx_en",  if_b.tx_en,     e[EXP_W-1]);
    check_eq("p0_blank",  if_b.rx_blank,  e[0]);
    @(negedge clk);
  endtask

  task automatic run(input logic rf, input int n);
    repeat (n) step(rf, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx"},    if_a.tx_en,     0);
    check_eq({tag, "_car"},   if_a.carrier,   0);
    check_eq({tag, "_blank"}, if_a.rx_blank,  0);
    check_eq({tag, "_idx"},   if_a.pulse_idx, 0);
    check_eq({tag, "_err"},   if_a.err,       0);
    check_eq({tag, "_p0tx"},  if_b.tx_en,     0);
  endtask

  initial begin
    logic [IDX_W-1:0] idx0;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    if_a.rf_in = 1'b0;
    if_a.clr = 1'b0;
    if_a.ftw = 16'h1000;
    if_a.phase_odd = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // single 10-cycle pulse
    run(1'b0, 5);
    run(1'b1, 10);
    run(1'b0, 25);
    check_eq("single_idx", if_a.pulse_idx, 1);

    // spin-echo: 10/20/20/20/10 with phase shift on the middle pulse
    if_a.ftw = 16'h4000;
    if_a.phase_odd = 16'h8000;
    step(1'b0, 1'b1);
    run(1'b0, 3);
    run(1'b1, 10); run(1'b0, 20);
    run(1'b1, 20); run(1'b0, 20);
    run(1'b1, 10); run(1'b0, 25);
    check_eq("echo_idx", if_a.pulse_idx, 3);

    // short gap keeps rx_blank high across both pulses
    idx0 = if_a.pulse_idx;
    run(1'b1, 8); run(1'b0, 5); run(1'b1, 8); run(1'b0, 25);
    check_eq("gap_idx", if_a.pulse_idx, 32'(idx0 + 2'd2));

    // runt then clear
    run(1'b1, 1); run(1'b0, 15);
    check_eq("runt_err", if_a.err, 1);
    step(1'b0, 1'b1);
    check_eq("clr_err", if_a.err, 0);
    run(1'b0, 3);

    // random pulse trains, tuning words and occasional clears
    for (int p = 0; p < 40; p++) begin
      if_a.ftw       = 16'($urandom_range(0, 16'hffff));
      if_a.phase_odd = 16'($urandom_range(0, 16'hffff));
      run(1'b1, $urandom_range(1, 12));
      step(1'b0, ($urandom_range(0, 9) == 0));
      run(1'b0, $urandom_range(0, 14));
    end
    run(1'b0, 15);

    // 256 pulses wrap pulse_idx
    step(1'b0, 1'b1);
    for (int p = 0; p < 256; p++) begin
      run(1'b1, 2);
      run(1'b0, 1);
    end
    run(1'b0, 15);
    check_eq("wrap_idx", if_a.pulse_idx, 0);

    // asynchronous reset in the middle of a pulse
    run(1'b1, 6);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    if_a.rf_in = 1'b1;
    rst_n = 1'b1;
    run(1'b1, 6);
    run(1'b0, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
